pipeline_ingress_arbiter: RTL and testbench
===========================================

# pipeline_ingress_arbiter

Round-robin arbiter and sequencer that shares the ingress of one stall-capable pipeline stage among `N_REQ` independent requesters. It selects one requester per cycle and forwards that requester's word and source tag into the stage's `inputs`/`in_valid` port, obeying the stage's `out_stall` back-pressure. It also drives the stage's `in_flush` through a fixed-length flush sequence, and blocks all grants while a flush is in progress.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥2.
- `DATA_W`, default 32: word width; matches the stage datapath.
- `FLUSH_CYCLES`, default 2: number of cycles `pipe_flush` is held high per flush; must be ≥1.
- `TAG_W`, default `$clog2(N_REQ)`: width of the source tag.
- `clk`, input, 1: clock.
- `reset`, input, 1: reset. Asynchronous, active-high.
- `req_valid`, input, `N_REQ`: requester i has a word pending.
- `req_data`, input, `N_REQ*DATA_W`: requester i's word, at bits `[i*DATA_W +: DATA_W]`.
- `req_ready`, output, `N_REQ`: one-hot or zero; requester i's word is accepted this cycle.
- `flush_req`, input, 1: one-cycle request to start a flush sequence.
- `pipe_stall`, input, 1: stage `out_stall` (its buffer is full).
- `pipe_data`, output, `DATA_W`: drives the stage's `inputs`.
- `pipe_valid`, output, 1: drives the stage's `in_valid`.
- `pipe_tag`, output, `TAG_W`: index of the requester whose word is on `pipe_data`.
- `pipe_flush`, output, 1: drives the stage's `in_flush`.
- `busy`, output, 1: high when the FSM is not in `RUN`.

## Operation
**FSM states:** `RUN`, `FLUSH`, `RECOVER`. The FSM enters `RUN` on reset.

**RUN**
- The grant is the first requester with `req_valid` high, searched cyclically starting at `rr_ptr`.
- `pipe_valid` = any `req_valid`.
- `pipe_data` = `req_data` of the granted requester; `pipe_tag` = its index.
- When nothing is valid, `pipe_data` and `pipe_tag` are 0.
- A transfer occurs when `pipe_valid & !pipe_stall`.
  - On a transfer, `req_ready[grant]` = 1 and `rr_ptr` ← (grant+1) mod `N_REQ`. The wrap from `N_REQ-1` goes to 0.
  - With no transfer, `req_ready` = 0 and `rr_ptr` holds.
- A requester must hold `req_valid` and its data until it sees `req_ready`.
- The grant can change while the stage is stalled. A higher-priority arrival may pre-empt the displayed word, because the stage only samples the word on acceptance.

**Entering FLUSH**
- `flush_req` in `RUN` moves the FSM to `FLUSH` next cycle and loads `flush_cnt` with `FLUSH_CYCLES-1`.
- A transfer in the same cycle as `flush_req` still completes.

**FLUSH**
- `pipe_flush` = 1; `pipe_valid` = 0; `req_ready` = 0.
- `flush_cnt` decrements each cycle. At 0 the FSM moves to `RECOVER`.
- `flush_req` received in `FLUSH` reloads `flush_cnt` to `FLUSH_CYCLES-1`, which extends the flush.
- `flush_req` received in `RECOVER` goes straight back to `FLUSH`.

**RECOVER**
- Lasts one cycle, with `pipe_flush` = 0, `pipe_valid` = 0 and `req_ready` = 0. The stage has then seen its flush deassert before new data arrives.
- The FSM then moves to `RUN`.
- `rr_ptr` resets to 0 on exit from `FLUSH`. Words already in the stage are discarded; requesters re-present their words.

**Reset**
- Reset may be asserted at any time, including mid-flush or mid-stall.
- It forces, asynchronously: state `RUN`, `rr_ptr` = 0, `flush_cnt` = 0.
- Outputs under reset: `pipe_flush` = 0, `busy` = 0, `pipe_valid`/`req_ready`/`pipe_data`/`pipe_tag` = 0 unless a requester is valid, in which case they follow the `RUN` rules.

## Timing
- `req_valid` → `pipe_valid`/`pipe_data`/`pipe_tag` is combinational, with zero-cycle latency.
- `pipe_stall` → `req_ready` is combinational, with no registered path.
- `pipe_flush` and `busy` come directly from registered state, so they are glitch-free.
- `flush_req` at edge n gives `pipe_flush` high for edges n+1 … n+`FLUSH_CYCLES`. `RECOVER` follows for one cycle. The first grant is possible `FLUSH_CYCLES`+2 cycles after `flush_req`.
- Throughput is one transfer per cycle when `pipe_stall` is low.
- With all requesters continuously valid, each is granted exactly once per `N_REQ` transfers.

## Structure
- A shared package `pipeline_pkg` holds:
  - the FSM state enum `arb_state_t` (`RUN`, `FLUSH`, `RECOVER`);
  - default `DATA_W`;
  - the `TAG_W` helper function.
- The one natural sub-module is `rr_picker`: a combinational rotate–priority-encode–unrotate. Its inputs are `req` and `ptr`; its outputs are `grant_idx` and `any`.
- The FSM, counter and pointer live in the top level.

## Test plan
- **Reset:** assert `reset` with `req_valid` = 0 → `pipe_valid` = 0, `pipe_flush` = 0, `busy` = 0, `rr_ptr` = 0. Release reset, then drive `req_valid` = 4'b0100 with data 0xA5A5_0002 → same-cycle `pipe_data` = 0xA5A5_0002, `pipe_tag` = 2, `req_ready` = 4'b0100.
- **Fairness:** hold all four `req_valid` high with `pipe_stall` = 0 for 8 cycles → tags 0,1,2,3,0,1,2,3, one per cycle.
- **Back-pressure:** `req_valid` = 4'b0011 with `pipe_stall` = 1 for 3 cycles → `req_ready` = 0 throughout, `pipe_tag` = 0 held. Drop the stall → tag 0 transfers, then tag 1 the next cycle.
- **Flush:** `FLUSH_CYCLES` = 2, pulse `flush_req` with requester 3 valid → the transfer completes that cycle. Then 2 cycles of `pipe_flush` = 1 with `req_ready` = 0, 1 cycle of `RECOVER`, then grant to tag 0 if valid (`rr_ptr` reset).
- **Flush extension:** a second `flush_req` in the last `FLUSH` cycle → `pipe_flush` stays high 2 further cycles. No grant until after `RECOVER`.
- **Async reset mid-flush:** assert `reset` in the first `FLUSH` cycle → `pipe_flush` drops before the next edge. After release, grants resume immediately with `rr_ptr` = 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the pipeline ingress arbiter.
package pipeline_pkg;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FLUSH   = 2'd1,
      RECOVER = 2'd2
   } arb_state_t;

   // Word width of the downstream stage datapath.
   localparam int DEFAULT_DATA_W = 32;

   // Index width for n items; never narrower than one bit.
   function automatic int tag_width(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/pipeline_ingress_arbiter_rr_picker.sv
// Round-robin picker: rotate the request vector so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_picker
   import pipeline_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int TAG_W = tag_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [TAG_W-1:0] ptr,
   output logic [TAG_W-1:0] grant_idx,
   output logic             any
);

   logic [N_REQ-1:0] rot;
   int               first;
   int               base;

   // Rotate, priority-encode from the pointer, unrotate.
   always_comb begin
      rot       = '0;
      first     = 0;
      grant_idx = '0;
      base      = int'(ptr);
      any       = |req;
      for (int k = 0; k < N_REQ; k++) begin
         rot[k] = req[(base + k) % N_REQ];
      end
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) first = k;
      end
      if (any) grant_idx = TAG_W'((base + first) % N_REQ);
   end

endmodule

// File: rtl/pipeline_ingress_arbiter.sv
// Round-robin ingress arbiter for one stall-capable pipeline stage, with a
// fixed-length flush sequence that blocks grants until the stage recovers.
module pipeline_ingress_arbiter
   import pipeline_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int DATA_W       = DEFAULT_DATA_W,
   parameter int FLUSH_CYCLES = 2,
   parameter int TAG_W        = tag_width(N_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      flush_req,
   input  logic                      pipe_stall,
   output logic [DATA_W-1:0]         pipe_data,
   output logic                      pipe_valid,
   output logic [TAG_W-1:0]          pipe_tag,
   output logic                      pipe_flush,
   output logic                      busy
);

   localparam int                 CNT_W      = tag_width(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [TAG_W-1:0]   LAST_IDX   = TAG_W'(N_REQ - 1);

   arb_state_t        state_q, state_d;
   logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic [TAG_W-1:0]  grant_idx;
   logic              any_req;
   logic              xfer;

   rr_picker #(
      .N_REQ (N_REQ),
      .TAG_W (TAG_W)
   ) u_picker (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant_idx (grant_idx),
      .any       (any_req)
   );

   // Flush and busy come straight from the state register so they never glitch.
   assign pipe_flush = (state_q == FLUSH);
   assign busy       = (state_q != RUN);

   // Forward the granted word to the stage; accept it only when not stalled.
   always_comb begin
      pipe_valid = 1'b0;
      pipe_data  = '0;
      pipe_tag   = '0;
      req_ready  = '0;
      xfer       = 1'b0;
      if (state_q == RUN && any_req) begin
         pipe_valid = 1'b1;
         pipe_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
         pipe_tag   = grant_idx;
         xfer       = !pipe_stall;
         if (xfer) req_ready[grant_idx] = 1'b1;
      end
   end

   // Next state, flush counter and round-robin pointer.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         RUN: begin
            // A transfer coinciding with flush_req still completes.
            if (xfer) begin
               rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + TAG_W'(1);
            end
            if (flush_req) begin
               state_d     = FLUSH;
               flush_cnt_d = CNT_RELOAD;
            end
         end
         FLUSH: begin
            if (flush_req) begin
               flush_cnt_d = CNT_RELOAD;
            end else if (flush_cnt_q == '0) begin
               // Anything the stage held is gone, so fairness restarts at 0.
               state_d  = RECOVER;
               rr_ptr_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q - CNT_W'(1);
            end
         end
         RECOVER: begin
            if (flush_req) begin
               state_d     = FLUSH;
               flush_cnt_d = CNT_RELOAD;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         rr_ptr_q    <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipeline_ingress_arbiter.sv
// Bench for pipeline_ingress_arbiter: directed vector table, hand-written
// async-reset sequence, then randomized traffic against a reference model.
module tb_pipeline_ingress_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int FC = 2;
   localparam int TW = 2;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            flush_req;
   logic            pipe_stall;
   logic [DW-1:0]   pipe_data;
   logic            pipe_valid;
   logic [TW-1:0]   pipe_tag;
   logic            pipe_flush;
   logic            busy;

   pipeline_ingress_arbiter #(
      .N_REQ        (N),
      .DATA_W       (DW),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .flush_req  (flush_req),
      .pipe_stall (pipe_stall),
      .pipe_data  (pipe_data),
      .pipe_valid (pipe_valid),
      .pipe_tag   (pipe_tag),
      .pipe_flush (pipe_flush),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   typedef struct {
      bit       rst;
      bit [3:0] rv;
      bit       stall;
      bit       fl;
      bit       ev;
      int       etag;
      bit [3:0] erdy;
      bit       efl;
      bit       ebusy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit rst, input bit [3:0] rv, input bit stall, input bit fl,
                      input bit ev, input int etag, input bit [3:0] erdy,
                      input bit efl, input bit ebusy);
      vec_t v;
      v.rst = rst; v.rv = rv; v.stall = stall; v.fl = fl;
      v.ev = ev; v.etag = etag; v.erdy = erdy; v.efl = efl; v.ebusy = ebusy;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic chk_all(input string nm, input bit ev, input int etag, input bit [3:0] erdy,
                          input logic [31:0] edata, input bit efl, input bit ebusy);
      chk({nm, ".valid"}, 64'(pipe_valid), 64'(ev));
      chk({nm, ".tag"},   64'(pipe_tag),   64'(etag));
      chk({nm, ".ready"}, 64'(req_ready),  64'(erdy));
      chk({nm, ".data"},  64'(pipe_data),  64'(edata));
      chk({nm, ".flush"}, 64'(pipe_flush), 64'(efl));
      chk({nm, ".busy"},  64'(busy),       64'(ebusy));
   endtask

   function automatic logic [31:0] pat(input int i);
      return 32'hA5A5_0000 | 32'(i);
   endfunction

   task automatic load_pattern();
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pat(i);
   endtask

   // Reference model: remaining flush cycles, a recover flag and the next-priority index.
   int  m_ptr, m_fl;
   bit  m_rec;
   bit  e_valid, e_fl, e_busy;
   int  e_tag;
   bit [3:0] e_rdy;
   logic [31:0] e_data;
   logic [31:0] rdata [N];

   task automatic model_expect(input bit [3:0] rv, input bit stall);
      e_valid = 0; e_tag = 0; e_rdy = '0; e_data = '0;
      e_fl = (m_fl > 0);
      e_busy = (m_fl > 0) || m_rec;
      if (!e_busy) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (rv[(m_ptr + k) % N]) e_tag = (m_ptr + k) % N;
         end
         if (rv != 0) begin
            e_valid = 1;
            e_data  = rdata[e_tag];
            if (!stall) e_rdy[e_tag] = 1'b1;
         end
      end
   endtask

   task automatic model_step(input bit stall, input bit fl);
      if (m_fl > 0) begin
         if (fl) m_fl = FC;
         else begin
            m_fl--;
            if (m_fl == 0) begin m_rec = 1; m_ptr = 0; end
         end
      end else if (m_rec) begin
         m_rec = 0;
         if (fl) m_fl = FC;
      end else begin
         if (e_valid && !stall) m_ptr = (e_tag + 1) % N;
         if (fl) m_fl = FC;
      end
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_data = '0; flush_req = 1'b0; pipe_stall = 1'b0;
      load_pattern();

      // rst rv stall fl | ev tag rdy fl busy
      add(1, 4'b0000, 0, 0,  0, 0, 4'b0000, 0, 0);  // reset, idle
      add(0, 4'b0100, 0, 0,  1, 2, 4'b0100, 0, 0);  // first grant to requester 2
      add(1, 4'b0000, 0, 0,  0, 0, 4'b0000, 0, 0);  // reset pulls pointer back to 0
      for (int i = 0; i < 8; i++) add(0, 4'b1111, 0, 0, 1, i % 4, 4'(1 << (i % 4)), 0, 0);
      for (int i = 0; i < 3; i++) add(0, 4'b0011, 1, 0, 1, 0, 4'b0000, 0, 0);
      add(0, 4'b0011, 0, 0,  1, 0, 4'b0001, 0, 0);  // stall drops, tag 0 goes
      add(0, 4'b0010, 0, 0,  1, 1, 4'b0010, 0, 0);  // then tag 1
      add(0, 4'b1000, 0, 1,  1, 3, 4'b1000, 0, 0);  // transfer alongside flush_req
      add(0, 4'b1000, 0, 0,  0, 0, 4'b0000, 1, 1);
      add(0, 4'b1000, 0, 0,  0, 0, 4'b0000, 1, 1);
      add(0, 4'b1000, 0, 0,  0, 0, 4'b0000, 0, 1);  // recover
      add(0, 4'b1001, 0, 0,  1, 0, 4'b0001, 0, 0);  // pointer restarted at 0
      add(0, 4'b0000, 0, 1,  0, 0, 4'b0000, 0, 0);
      add(0, 4'b1111, 0, 0,  0, 0, 4'b0000, 1, 1);
      add(0, 4'b1111, 0, 1,  0, 0, 4'b0000, 1, 1);  // extend in last flush cycle
      add(0, 4'b1111, 0, 0,  0, 0, 4'b0000, 1, 1);
      add(0, 4'b1111, 0, 0,  0, 0, 4'b0000, 1, 1);
      add(0, 4'b1111, 0, 0,  0, 0, 4'b0000, 0, 1);
      add(0, 4'b1111, 0, 0,  1, 0, 4'b0001, 0, 0);

      @(posedge clk); #1;
      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst; req_valid = tbl[i].rv;
         pipe_stall = tbl[i].stall; flush_req = tbl[i].fl;
         #4;
         chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].etag, tbl[i].erdy,
                 tbl[i].ev ? pat(tbl[i].etag) : 32'h0, tbl[i].efl, tbl[i].ebusy);
         @(posedge clk); #1;
      end
      reset = 1'b0; flush_req = 1'b0;

      // Async reset during the first flush cycle.
      req_valid = 4'b0010; flush_req = 1'b1;
      #4 chk_all("arst_pre", 1, 1, 4'b0010, pat(1), 0, 0);
      @(posedge clk); #1;
      flush_req = 1'b0; req_valid = 4'b0000;
      #2 chk("arst_inflush", 64'(pipe_flush), 64'd1);
      reset = 1'b1; req_valid = 4'b1111;
      #1 chk_all("arst_asserted", 1, 0, 4'b0001, pat(0), 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      #3 chk_all("arst_resume0", 1, 0, 4'b0001, pat(0), 0, 0);
      @(posedge clk); #1;
      #3 chk_all("arst_resume1", 1, 1, 4'b0010, pat(1), 0, 0);
      @(posedge clk); #1;

      // Randomized traffic against the model.
      m_ptr = 0; m_fl = 0; m_rec = 0;
      reset = 1'b1; req_valid = '0; flush_req = 1'b0; pipe_stall = 1'b0;
      @(posedge clk); #1;
      for (int c = 0; c < 600; c++) begin
         bit rst_c, st_c, fl_c;
         bit [3:0] rv_c;
         rst_c = ($urandom_range(0, 99) == 0);
         rv_c  = 4'($urandom_range(0, 15));
         st_c  = ($urandom_range(0, 2) == 0);
         fl_c  = ($urandom_range(0, 14) == 0);
         for (int i = 0; i < N; i++) begin
            rdata[i] = $urandom;
            req_data[i*DW +: DW] = rdata[i];
         end
         reset = rst_c; req_valid = rv_c; pipe_stall = st_c; flush_req = fl_c;
         if (rst_c) begin m_ptr = 0; m_fl = 0; m_rec = 0; end
         model_expect(rv_c, st_c);
         #4 chk_all($sformatf("rnd%0d", c), e_valid, e_tag, e_rdy, e_data, e_fl, e_busy);
         @(posedge clk);
         if (!rst_c) model_step(st_c, fl_c);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
